// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder
// Turns a stream of serial colour bits into fixed-period WS2812 high/low
// pulses on a single data line, and on request holds the line low for the
// strip's latch/reset period. One shared counter times both the bit period
// and the latch period.
module ws2812_bit_encoder #(
   parameter int T0H     = 20,
   parameter int T1H     = 40,
   parameter int T_BIT   = 63,
   parameter int T_RESET = 2500,
   parameter int CNT_W   = 12
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bit_in,
   input  logic bit_valid,
   output logic bit_ready,
   input  logic latch_req,
   output logic dout,
   output logic busy,
   output logic latch_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BIT   = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] T0H_C    = CNT_W'(T0H);
   localparam logic [CNT_W-1:0] T1H_C    = CNT_W'(T1H);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(T_BIT - 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(T_RESET - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             bit_r, bit_s;
   logic             dout_r, dout_s;
   logic             done_r, done_s;
   logic             pend_r, pend_s;

   logic             ready_s;
   logic             accept_s;
   logic             bit_end_s;
   logic             latch_end_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [CNT_W-1:0] th_s;

   assign bit_end_s   = (state_r == BIT)   && (cnt_r == BIT_LAST);
   assign latch_end_s = (state_r == LATCH) && (cnt_r == RST_LAST);
   assign cnt_inc_s   = cnt_r + CNT_ONE;
   assign th_s        = bit_r ? T1H_C : T0H_C;
   assign accept_s    = bit_valid && ready_s;

   // Ready: always in IDLE, and at the last cycle of a bit unless a latch is
   // waiting; held low while the block is in reset.
   always_comb begin
      ready_s = 1'b0;
      if (!rst_n) begin
         ready_s = 1'b0;
      end else if (state_r == IDLE) begin
         ready_s = 1'b1;
      end else if (bit_end_s && !pend_r) begin
         ready_s = 1'b1;
      end else begin
         ready_s = 1'b0;
      end
   end

   // Next-state, counter, captured bit, pending-latch and output decode.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      bit_s   = bit_r;
      dout_s  = 1'b0;
      done_s  = 1'b0;
      // A new request always wins over the clear on LATCH entry, so a
      // request arriving on that very edge still earns its own period.
      pend_s  = pend_r | latch_req;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = BIT;
               cnt_s   = CNT_ZERO;
               bit_s   = bit_in;
               dout_s  = 1'b1;
            end else if (pend_r) begin
               state_s = LATCH;
               cnt_s   = CNT_ZERO;
               pend_s  = latch_req;
            end else begin
               state_s = IDLE;
            end
         end
         BIT: begin
            if (bit_end_s) begin
               if (accept_s) begin
                  state_s = BIT;
                  cnt_s   = CNT_ZERO;
                  bit_s   = bit_in;
                  dout_s  = 1'b1;
               end else if (pend_r) begin
                  state_s = LATCH;
                  cnt_s   = CNT_ZERO;
                  pend_s  = latch_req;
               end else begin
                  state_s = IDLE;
                  cnt_s   = CNT_ZERO;
               end
            end else begin
               cnt_s  = cnt_inc_s;
               dout_s = (cnt_inc_s < th_s);
            end
         end
         LATCH: begin
            if (latch_end_s) begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
               done_s  = 1'b1;
            end else begin
               cnt_s = cnt_inc_s;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // State and output registers; reset drops the line and discards any work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         bit_r   <= 1'b0;
         dout_r  <= 1'b0;
         done_r  <= 1'b0;
         pend_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         bit_r   <= bit_s;
         dout_r  <= dout_s;
         done_r  <= done_s;
         pend_r  <= pend_s;
      end
   end

   assign bit_ready  = ready_s;
   assign dout       = dout_r;
   assign latch_done = done_r;
   assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Testbench for ws2812_bit_encoder: directed scenarios plus random traffic,
// checked every cycle against a timeline model of the data line.
module tb_ws2812_bit_encoder;

   localparam int T0H     = 20;
   localparam int T1H     = 40;
   localparam int T_BIT   = 63;
   localparam int T_RESET = 2500;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic latch_req = 1'b0;
   logic bit_ready, dout, busy, latch_done;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Model: current segment kind (0 idle, 1 bit, 2 latch) and cycles elapsed in it.
   int m_kind = 0;
   int m_el = 0;
   bit m_bit = 1'b0;
   bit m_pend = 1'b0;
   bit m_done = 1'b0;
   bit m_acc = 1'b0;

   int rise_q[$];
   int width_q[$];
   int done_q[$];
   bit prev_dout = 1'b0;
   int last_rise = 0;

   logic [23:0] pat;
   int exp_w[24] = '{40, 40, 40, 40, 40, 40, 40, 40,
                     20, 20, 20, 20, 20, 20, 20, 20,
                     40, 20, 40, 20, 20, 40, 20, 40};

   ws2812_bit_encoder #(
      .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT), .T_RESET(T_RESET), .CNT_W(12)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bit_in(bit_in),
      .bit_valid(bit_valid),
      .bit_ready(bit_ready),
      .latch_req(latch_req),
      .dout(dout),
      .busy(busy),
      .latch_done(latch_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int th(input bit b);
      return b ? T1H : T0H;
   endfunction

   function automatic bit e_ready();
      return rst_n && ((m_kind == 0) || ((m_kind == 1) && (m_el == T_BIT - 1) && !m_pend));
   endfunction

   function automatic bit e_dout();
      return (m_kind == 1) && (m_el < th(m_bit));
   endfunction

   task automatic model_reset();
      m_kind = 0; m_el = 0; m_bit = 1'b0; m_pend = 1'b0; m_done = 1'b0; m_acc = 1'b0;
   endtask

   // Advance the timeline model by one clock edge using the inputs just sampled.
   task automatic model_edge(input bit v, input bit b, input bit l);
      bit np;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_acc  = v && e_ready();
      np     = m_pend | l;
      m_done = 1'b0;
      if (m_kind == 0) begin
         if (m_acc) begin m_kind = 1; m_el = 0; m_bit = b; end
         else if (m_pend) begin m_kind = 2; m_el = 0; np = l; end
      end else if (m_kind == 1) begin
         if (m_el == T_BIT - 1) begin
            if (m_acc) begin m_kind = 1; m_el = 0; m_bit = b; end
            else if (m_pend) begin m_kind = 2; m_el = 0; np = l; end
            else begin m_kind = 0; m_el = 0; end
         end else begin
            m_el = m_el + 1;
         end
      end else begin
         if (m_el == T_RESET - 1) begin m_kind = 0; m_el = 0; m_done = 1'b1; end
         else m_el = m_el + 1;
      end
      m_pend = np;
   endtask

   task automatic chk(input string nm, input int got, input int expv);
      checks = checks + 1;
      if (got != expv) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, expv, cyc);
      end
   endtask

   // One clock: drive inputs, wait for the edge, step the model, settle 1 time unit.
   task automatic cycle(input bit v, input bit b, input bit l);
      bit_valid = v; bit_in = b; latch_req = l;
      @(posedge clk);
      model_edge(v, b, l);
      #1;
   endtask

   task automatic wait_idle(input int maxc, input string nm);
      for (int n = 0; n < maxc && busy; n++) cycle(1'b0, 1'b0, 1'b0);
      chk(nm, int'(busy), 0);
   endtask

   task automatic clear_q();
      rise_q.delete(); width_q.delete(); done_q.delete();
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      chk("dout", int'(dout), int'(e_dout()));
      chk("busy", int'(busy), int'(m_kind != 0));
      chk("latch_done", int'(latch_done), int'(m_done));
      chk("bit_ready", int'(bit_ready), int'(e_ready()));
   end

   // Pulse monitor: records rising-edge cycles, high widths and latch_done cycles.
   always @(negedge clk) begin
      if (dout && !prev_dout) begin rise_q.push_back(cyc); last_rise = cyc; end
      if (!dout && prev_dout) width_q.push_back(cyc - last_rise);
      if (latch_done) done_q.push_back(cyc);
      prev_dout = dout;
   end

   initial begin
      int k, idx, guard, idle_cyc;

      // Reset held with bit_valid high.
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      chk("rst_dout", int'(dout), 0);
      chk("rst_ready", int'(bit_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(latch_done), 0);
      bit_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("rel_ready", int'(bit_ready), 1);
      cycle(1'b0, 1'b0, 1'b0);

      // Single '0' bit with exact ready / idle timing.
      clear_q();
      cycle(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 63; i++) begin
         cycle(1'b0, 1'b0, 1'b0);
         if (i == 61) chk("b0_ready_61", int'(bit_ready), 0);
         if (i == 62) begin
            chk("b0_ready_62", int'(bit_ready), 1);
            chk("b0_busy_62", int'(busy), 1);
         end
         if (i == 63) chk("b0_busy_63", int'(busy), 0);
      end
      cycle(1'b0, 1'b0, 1'b0);
      chk("b0_nrise", rise_q.size(), 1);
      chk("b0_width", (width_q.size() > 0) ? width_q[0] : -1, 20);

      // Single '1' bit.
      clear_q();
      cycle(1'b1, 1'b1, 1'b0);
      wait_idle(200, "b1_idle");
      cycle(1'b0, 1'b0, 1'b0);
      chk("b1_width", (width_q.size() > 0) ? width_q[0] : -1, 40);

      // 24 back-to-back bits of 0xFF00A5.
      clear_q();
      pat = 24'hFF00A5;
      idx = 0;
      guard = 0;
      while (idx < 24 && guard < 3000) begin
         cycle(1'b1, pat[23 - idx], 1'b0);
         if (m_acc) idx++;
         guard++;
      end
      wait_idle(200, "px_idle");
      idle_cyc = cyc;
      cycle(1'b0, 1'b0, 1'b0);
      chk("px_nrise", rise_q.size(), 24);
      chk("px_nwidth", width_q.size(), 24);
      for (int i = 1; i < rise_q.size(); i++) chk("px_period", rise_q[i] - rise_q[i - 1], 63);
      for (int i = 0; i < width_q.size() && i < 24; i++) chk("px_width", width_q[i], exp_w[i]);
      chk("px_total", (rise_q.size() > 0) ? idle_cyc - rise_q[0] : -1, 1512);

      // Bit and latch request together in IDLE: bit first, then the latch.
      clear_q();
      cycle(1'b1, 1'b1, 1'b1);
      k = cyc;
      wait_idle(3000, "lt_idle");
      cycle(1'b0, 1'b0, 1'b0);
      chk("lt_width", (width_q.size() > 0) ? width_q[0] : -1, 40);
      chk("lt_ndone", done_q.size(), 1);
      chk("lt_done_at", (done_q.size() > 0) ? done_q[0] : -1, k + 63 + 2500);

      // Asynchronous reset mid-'1'-bit with a latch pending.
      cycle(1'b1, 1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("ar_dout", int'(dout), 0);
      chk("ar_busy", int'(busy), 0);
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      clear_q();
      cycle(1'b1, 1'b1, 1'b0);
      wait_idle(200, "ar_idle");
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      chk("ar_width", (width_q.size() > 0) ? width_q[0] : -1, 40);
      chk("ar_nwidth", width_q.size(), 1);
      chk("ar_ndone", done_q.size(), 0);
      chk("ar_busy_end", int'(busy), 0);

      // Random traffic with sparse latch requests.
      for (int i = 0; i < 6000; i++)
         cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), ($urandom_range(0, 399) == 0));
      for (int i = 0; i < 8000 && (busy || m_pend); i++) cycle(1'b0, 1'b0, 1'b0);
      chk("rnd_drain", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
